ibex_obi_bus_env: RTL and testbench
===================================

# ibex_obi_bus_env

Parametrised formal bus environment for one Ibex OBI port (instruction or data) inside the riscv-formal wrapper. It replaces free-running random `gnt`/`rvalid`/`rdata`/`err` inputs with protocol-legal responses built from nondeterministic inputs. It tracks outstanding transactions and checks that the core holds its request stable until granted. With `FAIRNESS=1` it bounds grant and response stalls, so liveness checks become provable. One instance is placed per core bus port in the wrapper.

## Interface
Parameters:
- `AW`, 32: address width.
- `DW`, 32: data width, multiple of 8.
- `MAX_OUTSTANDING`, 2: maximum granted-but-unanswered transactions, 1..8.
- `MAX_STALL`, 4: fairness bound in cycles, ≥1.
- `FAIRNESS`, 0: 1 forces grant/response once a stall reaches `MAX_STALL`.
- `ERR_EN`, 1: 0 ties `err_o` low.

Ports:
- `clock` in 1: single clock. All state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `req_i` in 1: core request.
- `addr_i` in AW: core address.
- `we_i` in 1: core write enable.
- `be_i` in DW/8: core byte enables.
- `wdata_i` in DW: core write data.
- `gnt_o` out 1: grant to core.
- `rvalid_o` out 1: response valid to core.
- `rdata_o` out DW: response read data.
- `err_o` out 1: response error.
- `rand_gnt_i`, `rand_rvalid_i`, `rand_err_i` in 1: nondeterministic choices (rand regs at wrapper level).
- `rand_rdata_i` in DW: nondeterministic read data.
- `outstanding_o` out $clog2(MAX_OUTSTANDING+1): current outstanding count.
- `rsp_we_o` out 1: `we` of the transaction being answered.
- `rsp_addr_o` out AW: address of the transaction being answered.
- `req_viol_o` out 1: sticky core-side protocol violation flag.

## Operation
- Outstanding FIFO, depth `MAX_OUTSTANDING`, entries {we, addr}.
  - Push on `gnt_o`; pop on `rvalid_o`.
  - Pointers wrap modulo depth; occupancy counter `cnt`, with `outstanding_o = cnt`.
- Grant: `gnt_o = req_i & (cnt < MAX_OUTSTANDING) & (rand_gnt_i | force_gnt)`.
  - Grant is never given when full, including when `force_gnt` is set.
- Response: `rvalid_o = (cnt != 0) & (rand_rvalid_i | force_rsp)`.
  - `cnt` is registered, so a response is never issued in the same cycle as its grant. Minimum gnt→rvalid latency is 1 cycle.
- Response order is strictly FIFO. `rsp_we_o`/`rsp_addr_o` show the head entry and are 0 when empty.
- Read data: `rdata_o = (rvalid_o & ~rsp_we_o) ? rand_rdata_i : 0`. Writes always return 0.
- Error: `err_o = ERR_EN & rvalid_o & rand_err_i`. An error response still pops the entry.
- Simultaneous grant and response: push and pop in the same cycle, so `cnt` is unchanged.
  - When full, a same-cycle pop does not enable a grant; the full check uses the registered `cnt`.
- Stall counters, each saturating at `MAX_STALL`:
  - `gstall`: increments while `req_i & ~gnt_o`; clears otherwise.
  - `rstall`: increments while `cnt != 0 & ~rvalid_o`; clears otherwise.
  - `force_gnt = FAIRNESS & (gstall == MAX_STALL)`; `force_rsp = FAIRNESS & (rstall == MAX_STALL)`.
  - When `FAIRNESS=0`, both forces are tied 0 and the counters are still maintained.
- Core-side checker, 2-state FSM:
  - IDLE → WAIT on `req_i & ~gnt_o`, capturing {addr, we, be, wdata} (wdata captured only when `we_i`).
  - WAIT → IDLE on `gnt_o`.
  - In WAIT, any of the following sets `req_viol_o` (sticky until reset): `req_i` low, a change in captured addr/we/be, or a change in wdata when `we`.
  - The check in WAIT uses the current cycle's inputs against the captured values.

## Timing
- Reset (synchronous, `reset` high at edge): `cnt=0`, pointers 0, `gstall=rstall=0`, FSM IDLE, `req_viol_o=0`.
- While `reset` is high, `gnt_o`, `rvalid_o`, `err_o` and `rdata_o` are forced to 0 combinationally.
- Reset asserted mid-transaction drops all outstanding entries with no response.
- Combinational paths: `gnt_o`, `rvalid_o`, `rdata_o` and `err_o` depend combinationally on `rand_*_i`; `gnt_o` also depends on `req_i`. There is no path `req_i`→`rvalid_o`.
- With `FAIRNESS=1`:
  - A pending request is granted within `MAX_STALL+1` cycles, provided the FIFO is not full.
  - The head entry is answered within `MAX_STALL+1` cycles of becoming head.

## Test plan
- Reset, then `req_i=1`, `rand_gnt_i=1` for 1 cycle → `gnt_o=1` that cycle; `outstanding_o=1` next cycle. `rvalid_o=0` in the grant cycle even with `rand_rvalid_i=1`.
- `MAX_OUTSTANDING=2`: three back-to-back requests with `rand_gnt_i=1`, `rand_rvalid_i=0` → two grants, third held with `gnt_o=0`. Set `rand_rvalid_i=1` for 1 cycle → `cnt` 2→1, and the third request is granted the following cycle.
- Write to 0x100 then read from 0x200, `rand_rdata_i=0xDEADBEEF` → first response has `rsp_we_o=1`, `rsp_addr_o=0x100`, `rdata_o=0`; second has `rsp_addr_o=0x200`, `rdata_o=0xDEADBEEF`.
- `FAIRNESS=1`, `MAX_STALL=4`, `req_i=1`, `rand_gnt_i=0` throughout → `gnt_o=1` exactly on the 5th request cycle. The same holds for `rvalid_o` with `rand_rvalid_i=0`.
- `req_i=1`, `addr_i=0x40`, no grant for 1 cycle, then `addr_i=0x44` → `req_viol_o=1` the next cycle and it stays 1; a later reset clears it to 0.
- `ERR_EN=0`, `rand_err_i=1` with a response → `err_o=0` and the entry pops. Same stimulus with `ERR_EN=1` → `err_o=1` and the entry pops.

Source files
------------

// File: rtl/ibex_obi_bus_env.sv
// Protocol-legal OBI responder for one Ibex bus port in the formal wrapper:
// bounded in-order outstanding FIFO, optional fairness, and a request-stability checker.
module ibex_obi_bus_env #(
  parameter int AW              = 32,
  parameter int DW              = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter int MAX_STALL       = 4,
  parameter int FAIRNESS        = 0,
  parameter int ERR_EN          = 1,
  localparam int CW             = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req_i,
  input  logic [AW-1:0]   addr_i,
  input  logic            we_i,
  input  logic [DW/8-1:0] be_i,
  input  logic [DW-1:0]   wdata_i,
  output logic            gnt_o,
  output logic            rvalid_o,
  output logic [DW-1:0]   rdata_o,
  output logic            err_o,
  input  logic            rand_gnt_i,
  input  logic            rand_rvalid_i,
  input  logic            rand_err_i,
  input  logic [DW-1:0]   rand_rdata_i,
  output logic [CW-1:0]   outstanding_o,
  output logic            rsp_we_o,
  output logic [AW-1:0]   rsp_addr_o,
  output logic            req_viol_o
);

  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int SW = $clog2(MAX_STALL + 1);
  localparam logic [PW-1:0] LAST_PTR  = PW'(MAX_OUTSTANDING - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(MAX_OUTSTANDING);
  localparam logic [SW-1:0] STALL_MAX = SW'(MAX_STALL);

  typedef enum logic {ST_IDLE, ST_WAIT} chk_state_t;

  logic            fifo_we   [MAX_OUTSTANDING];
  logic [AW-1:0]   fifo_addr [MAX_OUTSTANDING];
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   rptr;
  logic [CW-1:0]   cnt;
  logic [SW-1:0]   gstall;
  logic [SW-1:0]   rstall;
  logic            full;
  logic            busy;
  logic            force_gnt;
  logic            force_rsp;

  chk_state_t      state;
  logic [AW-1:0]   cap_addr;
  logic            cap_we;
  logic [DW/8-1:0] cap_be;
  logic [DW-1:0]   cap_wdata;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign full      = (cnt == FULL_CNT);
  assign busy      = (cnt != '0);
  assign force_gnt = (FAIRNESS != 0) && (gstall == STALL_MAX);
  assign force_rsp = (FAIRNESS != 0) && (rstall == STALL_MAX);

  // The full check uses registered cnt, so a same-cycle pop never frees a slot early.
  assign gnt_o    = ~reset & req_i & ~full & (rand_gnt_i | force_gnt);
  assign rvalid_o = ~reset & busy & (rand_rvalid_i | force_rsp);

  assign rsp_we_o      = busy ? fifo_we[rptr]   : 1'b0;
  assign rsp_addr_o    = busy ? fifo_addr[rptr] : '0;
  assign rdata_o       = (rvalid_o & ~rsp_we_o) ? rand_rdata_i : '0;
  assign err_o         = (ERR_EN != 0) && rvalid_o && rand_err_i;
  assign outstanding_o = cnt;

  always_ff @(posedge clock) begin
    if (gnt_o) begin
      fifo_we[wptr]   <= we_i;
      fifo_addr[wptr] <= addr_i;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr   <= '0;
      rptr   <= '0;
      cnt    <= '0;
      gstall <= '0;
      rstall <= '0;
    end else begin
      if (gnt_o)    wptr <= ptr_inc(wptr);
      if (rvalid_o) rptr <= ptr_inc(rptr);
      case ({gnt_o, rvalid_o})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (req_i && !gnt_o) begin
        if (gstall != STALL_MAX) gstall <= gstall + 1'b1;
      end else begin
        gstall <= '0;
      end
      if (busy && !rvalid_o) begin
        if (rstall != STALL_MAX) rstall <= rstall + 1'b1;
      end else begin
        rstall <= '0;
      end
    end
  end

  // A request left waiting must stay asserted and unchanged until it is granted.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      req_viol_o <= 1'b0;
      cap_addr   <= '0;
      cap_we     <= 1'b0;
      cap_be     <= '0;
      cap_wdata  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_i && !gnt_o) begin
            state    <= ST_WAIT;
            cap_addr <= addr_i;
            cap_we   <= we_i;
            cap_be   <= be_i;
            if (we_i) cap_wdata <= wdata_i;
          end
        end
        ST_WAIT: begin
          if (!req_i || (addr_i != cap_addr) || (we_i != cap_we) || (be_i != cap_be) ||
              (cap_we && (wdata_i != cap_wdata)))
            req_viol_o <= 1'b1;
          if (gnt_o) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ibex_obi_bus_env.sv
// Bench for ibex_obi_bus_env: two instances (A: no fairness, errors on; B: fairness, errors off)
// share stimulus and are checked every cycle against a queue-based behavioural model.
module tb_ibex_obi_bus_env;

  localparam int DEPTH     = 2;
  localparam int MAX_STALL = 4;

  typedef struct packed {
    int                     n;
    logic [DEPTH-1:0]       we;
    logic [DEPTH-1:0][31:0] addr;
    int                     gst;
    int                     rst;
    logic                   waiting;
    logic                   viol;
    logic [31:0]            caddr;
    logic                   cwe;
    logic [3:0]             cbe;
    logic [31:0]            cwd;
  } model_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    logic [1:0]  outst;
    logic        rwe;
    logic [31:0] raddr;
    logic        viol;
  } obs_t;

  logic        clock;
  logic        reset;
  logic        req;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        rg;
  logic        rr;
  logic        re;
  logic [31:0] rd;

  logic        gnt_a, rvalid_a, err_a, rwe_a, viol_a;
  logic [31:0] rdata_a, raddr_a;
  logic [1:0]  outst_a;
  logic        gnt_b, rvalid_b, err_b, rwe_b, viol_b;
  logic [31:0] rdata_b, raddr_b;
  logic [1:0]  outst_b;

  int     checks;
  int     failures;
  model_t ma;
  model_t mb;
  obs_t   snap_a;
  obs_t   snap_b;
  obs_t   obs_a;
  obs_t   obs_b;

  ibex_obi_bus_env #(.AW(32), .DW(32), .MAX_OUTSTANDING(DEPTH), .MAX_STALL(MAX_STALL),
                     .FAIRNESS(0), .ERR_EN(1)) u_a (
    .clock(clock), .reset(reset), .req_i(req), .addr_i(addr), .we_i(we), .be_i(be),
    .wdata_i(wdata), .gnt_o(gnt_a), .rvalid_o(rvalid_a), .rdata_o(rdata_a), .err_o(err_a),
    .rand_gnt_i(rg), .rand_rvalid_i(rr), .rand_err_i(re), .rand_rdata_i(rd),
    .outstanding_o(outst_a), .rsp_we_o(rwe_a), .rsp_addr_o(raddr_a), .req_viol_o(viol_a)
  );

  ibex_obi_bus_env #(.AW(32), .DW(32), .MAX_OUTSTANDING(DEPTH), .MAX_STALL(MAX_STALL),
                     .FAIRNESS(1), .ERR_EN(0)) u_b (
    .clock(clock), .reset(reset), .req_i(req), .addr_i(addr), .we_i(we), .be_i(be),
    .wdata_i(wdata), .gnt_o(gnt_b), .rvalid_o(rvalid_b), .rdata_o(rdata_b), .err_o(err_b),
    .rand_gnt_i(rg), .rand_rvalid_i(rr), .rand_err_i(re), .rand_rdata_i(rd),
    .outstanding_o(outst_b), .rsp_we_o(rwe_b), .rsp_addr_o(raddr_b), .req_viol_o(viol_b)
  );

  assign obs_a = {gnt_a, rvalid_a, rdata_a, err_a, outst_a, rwe_a, raddr_a, viol_a};
  assign obs_b = {gnt_b, rvalid_b, rdata_b, err_b, outst_b, rwe_b, raddr_b, viol_b};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic obs_t predict(input model_t m, input int fair, input int err_en);
    obs_t e;
    e        = '0;
    e.gnt    = !reset && req && (m.n < DEPTH) && (rg || (fair != 0 && m.gst >= MAX_STALL));
    e.rvalid = !reset && (m.n > 0) && (rr || (fair != 0 && m.rst >= MAX_STALL));
    e.rwe    = (m.n > 0) ? m.we[0] : 1'b0;
    e.raddr  = (m.n > 0) ? m.addr[0] : 32'h0;
    e.rdata  = (e.rvalid && !e.rwe) ? rd : 32'h0;
    e.err    = (err_en != 0) && e.rvalid && re;
    e.outst  = 2'(m.n);
    e.viol   = m.viol;
    return e;
  endfunction

  function automatic model_t advance(input model_t m, input obs_t e);
    int n0;
    if (reset) return '0;
    n0 = m.n;
    if (e.rvalid) begin
      for (int k = 0; k < DEPTH - 1; k++) begin
        m.we[k]   = m.we[k+1];
        m.addr[k] = m.addr[k+1];
      end
      m.n = m.n - 1;
    end
    if (e.gnt) begin
      m.we[m.n]   = we;
      m.addr[m.n] = addr;
      m.n = m.n + 1;
    end
    m.gst = (req && !e.gnt) ? ((m.gst < MAX_STALL) ? m.gst + 1 : MAX_STALL) : 0;
    m.rst = (n0 > 0 && !e.rvalid) ? ((m.rst < MAX_STALL) ? m.rst + 1 : MAX_STALL) : 0;
    if (m.waiting) begin
      if (!req || addr != m.caddr || we != m.cwe || be != m.cbe || (m.cwe && wdata != m.cwd))
        m.viol = 1'b1;
      if (e.gnt) m.waiting = 1'b0;
    end else if (req && !e.gnt) begin
      m.waiting = 1'b1;
      m.caddr   = addr;
      m.cwe     = we;
      m.cbe     = be;
      if (we) m.cwd = wdata;
    end
    return m;
  endfunction

  task automatic chk(input string name, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag, input obs_t o, input obs_t e);
    chk({tag, "_gnt"},    32'(o.gnt),    32'(e.gnt));
    chk({tag, "_rvalid"}, 32'(o.rvalid), 32'(e.rvalid));
    chk({tag, "_rdata"},  o.rdata,       e.rdata);
    chk({tag, "_err"},    32'(o.err),    32'(e.err));
    chk({tag, "_outst"},  32'(o.outst),  32'(e.outst));
    chk({tag, "_rsp_we"}, 32'(o.rwe),    32'(e.rwe));
    chk({tag, "_rsp_ad"}, o.raddr,       e.raddr);
    chk({tag, "_viol"},   32'(o.viol),   32'(e.viol));
  endtask

  // One clock cycle with the current inputs: compare on the falling edge, advance models on the rising edge.
  task automatic tick();
    obs_t ea;
    obs_t eb;
    @(negedge clock);
    ea = predict(ma, 0, 1);
    eb = predict(mb, 1, 0);
    snap_a = obs_a;
    snap_b = obs_b;
    checkOutput("a", snap_a, ea);
    checkOutput("b", snap_b, eb);
    @(posedge clock);
    ma = advance(ma, ea);
    mb = advance(mb, eb);
    #1;
  endtask

  task automatic applyStimulus(input logic rq, input logic [31:0] ad, input logic w,
                               input logic g, input logic v, input logic e, input logic [31:0] d);
    req   = rq;
    addr  = ad;
    we    = w;
    be    = 4'hf;
    wdata = ad ^ 32'h5a5a0000;
    rg    = g;
    rr    = v;
    re    = e;
    rd    = d;
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    ma = '0;
    mb = '0;
    reset = 1'b1;
    req = 0; addr = 0; we = 0; be = 0; wdata = 0; rg = 0; rr = 0; re = 0; rd = 0;
    repeat (2) @(posedge clock);
    #1;

    // Outputs stay quiet while reset is held, even with every random choice asserted.
    applyStimulus(1, 32'h10, 0, 1, 1, 1, 32'hffff_ffff);
    chk("reset_gnt", 32'(snap_a.gnt), 32'd0);
    chk("reset_rdata", snap_a.rdata, 32'd0);
    reset = 1'b0;

    applyStimulus(1, 32'h10, 0, 1, 1, 0, 0);
    chk("first_gnt", 32'(snap_a.gnt), 32'd1);
    chk("first_no_same_cycle_rvalid", 32'(snap_a.rvalid), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    chk("first_outst", 32'(snap_a.outst), 32'd1);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);

    applyStimulus(1, 32'h20, 0, 1, 0, 0, 0);
    applyStimulus(1, 32'h24, 0, 1, 0, 0, 0);
    applyStimulus(1, 32'h28, 0, 1, 0, 0, 0);
    chk("full_no_gnt", 32'(snap_a.gnt), 32'd0);
    chk("full_outst", 32'(snap_a.outst), 32'd2);
    applyStimulus(1, 32'h28, 0, 1, 1, 0, 0);
    chk("full_pop_no_gnt", 32'(snap_a.gnt), 32'd0);
    chk("full_pop_rvalid", 32'(snap_a.rvalid), 32'd1);
    applyStimulus(1, 32'h28, 0, 1, 0, 0, 0);
    chk("third_gnt", 32'(snap_a.gnt), 32'd1);
    chk("third_outst", 32'(snap_a.outst), 32'd1);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);

    applyStimulus(1, 32'h100, 1, 1, 0, 0, 0);
    applyStimulus(1, 32'h200, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 32'hdeadbeef);
    chk("wr_rsp_we", 32'(snap_a.rwe), 32'd1);
    chk("wr_rsp_addr", snap_a.raddr, 32'h100);
    chk("wr_rdata", snap_a.rdata, 32'h0);
    applyStimulus(0, 0, 0, 0, 1, 0, 32'hdeadbeef);
    chk("rd_rsp_we", 32'(snap_a.rwe), 32'd0);
    chk("rd_rsp_addr", snap_a.raddr, 32'h200);
    chk("rd_rdata", snap_a.rdata, 32'hdeadbeef);

    // Fairness: B must grant and answer on exactly the fifth stalled cycle.
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1, 32'h300, 0, 0, 0, 0, 0);
      chk("fair_gnt_b", 32'(snap_b.gnt), 32'(i == 5));
      chk("nofair_gnt_a", 32'(snap_a.gnt), 32'd0);
    end
    for (int j = 1; j <= 5; j++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 32'h1234);
      chk("fair_rvalid_b", 32'(snap_b.rvalid), 32'(j == 5));
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    chk("fair_drained_b", 32'(snap_b.outst), 32'd0);

    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    applyStimulus(1, 32'h40, 0, 0, 0, 0, 0);
    applyStimulus(1, 32'h44, 0, 0, 0, 0, 0);
    applyStimulus(1, 32'h44, 0, 0, 0, 0, 0);
    chk("viol_set", 32'(snap_a.viol), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    chk("viol_sticky", 32'(snap_a.viol), 32'd1);
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    chk("viol_cleared", 32'(snap_a.viol), 32'd0);

    applyStimulus(1, 32'h500, 1, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 1, 0);
    chk("err_on_a", 32'(snap_a.err), 32'd1);
    chk("err_off_b", 32'(snap_b.err), 32'd0);
    chk("err_rvalid_b", 32'(snap_b.rvalid), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    chk("err_pop_a", 32'(snap_a.outst), 32'd0);
    chk("err_pop_b", 32'(snap_b.outst), 32'd0);

    // Randomised traffic; requests are mostly held stable while waiting, with occasional violations and resets.
    for (int c = 0; c < 800; c++) begin
      reset = ($urandom_range(0, 99) == 0);
      if (!(ma.waiting && $urandom_range(0, 15) != 0)) begin
        req   = ($urandom_range(0, 2) != 0);
        addr  = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
        we    = 1'($urandom_range(0, 1));
        be    = 4'($urandom_range(0, 15));
        wdata = $urandom;
      end
      rg = ($urandom_range(0, 3) == 0);
      rr = ($urandom_range(0, 2) == 0);
      re = 1'($urandom_range(0, 1));
      rd = $urandom;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
